// File: rtl/alu_op_sequencer_if.sv
// +--------------------------------------------------------------------+
// | alu_op_sequencer_if: operand/result bus between control, ALU and    |
// | the ALU op sequencer.                        Rev 1.0                |
// +--------------------------------------------------------------------+
`default_nettype none

interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             input_Start;
  logic [2:0]       input_Op;
  logic [1:0]       input_Branch;
  logic [WIDTH-1:0] input_RegA;
  logic [WIDTH-1:0] input_RegB;
  logic [WIDTH-1:0] input_Imm;
  logic             input_UseImm;
  logic [WIDTH-1:0] output_ALU_A;
  logic [WIDTH-1:0] output_ALU_B;
  logic [2:0]       output_ALUOp;
  logic [WIDTH-1:0] input_ALUResult;
  logic             input_Zero;
  logic             input_Negative;
  logic [WIDTH-1:0] output_ALUOut;
  logic             output_Zero;
  logic             output_Negative;
  logic             output_BranchTaken;
  logic             output_IllegalOp;
  logic             output_Busy;
  logic             output_Done;

  modport master (
    output input_Start, input_Op, input_Branch, input_RegA, input_RegB,
    output input_Imm, input_UseImm, input_ALUResult, input_Zero, input_Negative,
    input  output_ALU_A, output_ALU_B, output_ALUOp, output_ALUOut,
    input  output_Zero, output_Negative, output_BranchTaken, output_IllegalOp,
    input  output_Busy, output_Done
  );

  modport slave (
    input  input_Start, input_Op, input_Branch, input_RegA, input_RegB,
    input  input_Imm, input_UseImm, input_ALUResult, input_Zero, input_Negative,
    output output_ALU_A, output_ALU_B, output_ALUOp, output_ALUOut,
    output output_Zero, output_Negative, output_BranchTaken, output_IllegalOp,
    output output_Busy, output_Done
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// +--------------------------------------------------------------------+
// | alu_op_sequencer: IDLE/EXEC/DONE sequencer around an external ALU,  |
// | with operand latching, result/flag capture and branch decision.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_op_sequencer #(
  parameter int         WIDTH        = 16,
  parameter logic [2:0] SUB_OP       = 3'b001,
  parameter logic [2:0] MAX_LEGAL_OP = 3'b100
) (
  input  wire logic             input_CLK,
  input  wire logic             input_Reset_n,
  alu_op_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_BR_NONE = 2'b00;
  localparam logic [1:0] c_BR_BEQ  = 2'b01;
  localparam logic [1:0] c_BR_BNE  = 2'b10;
  localparam logic [1:0] c_BR_BLT  = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_busy;
  logic             w_done;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [1:0]       r_branch;
  logic             r_illegal_lat;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_negative;
  logic             r_branch_taken;
  logic             r_illegal;

  logic             w_req_illegal;
  logic             w_branch_taken;

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.input_Start) begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_busy       = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Branch compares always run as subtract, so an out-of-range Op is harmless there.
  assign w_req_illegal = (bus.input_Branch == c_BR_NONE) && (bus.input_Op > MAX_LEGAL_OP);

  always_comb begin
    w_branch_taken = 1'b0;
    case (r_branch)
      c_BR_BEQ: w_branch_taken = bus.input_Zero;
      c_BR_BNE: w_branch_taken = ~bus.input_Zero;
      c_BR_BLT: w_branch_taken = bus.input_Negative;
      default:  w_branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge input_CLK or negedge input_Reset_n) begin
    if (!input_Reset_n) begin
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_op       <= 3'b000;
      r_branch       <= c_BR_NONE;
      r_illegal_lat  <= 1'b0;
      r_alu_out      <= '0;
      r_zero         <= 1'b0;
      r_negative     <= 1'b0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.input_Start) begin
            r_alu_a       <= bus.input_RegA;
            r_alu_b       <= bus.input_UseImm ? bus.input_Imm : bus.input_RegB;
            r_alu_op      <= (bus.input_Branch != c_BR_NONE) ? SUB_OP : bus.input_Op;
            r_branch      <= bus.input_Branch;
            r_illegal_lat <= w_req_illegal;
          end
        end
        ST_EXEC: begin
          r_illegal <= r_illegal_lat;
          // An illegal op leaves the previous result and flags visible.
          if (!r_illegal_lat) begin
            r_alu_out      <= bus.input_ALUResult;
            r_zero         <= bus.input_Zero;
            r_negative     <= bus.input_Negative;
            r_branch_taken <= w_branch_taken;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.output_ALU_A       = r_alu_a;
  assign bus.output_ALU_B       = r_alu_b;
  assign bus.output_ALUOp       = r_alu_op;
  assign bus.output_ALUOut      = r_alu_out;
  assign bus.output_Zero        = r_zero;
  assign bus.output_Negative    = r_negative;
  assign bus.output_BranchTaken = r_branch_taken;
  assign bus.output_IllegalOp   = r_illegal;
  assign bus.output_Busy        = w_busy;
  assign bus.output_Done        = w_done;

  // c_BR_BLT is covered by the case above; keep the name referenced for readers.
  logic w_unused;
  assign w_unused = (c_BR_BLT == 2'b11);

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_alu_op_sequencer: directed self-checking bench with a behavioural |
// | model of the external 16-bit ALU.                Rev 1.0            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_op_sequencer;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  alu_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH)) dut (
    .input_CLK     (clk),
    .input_Reset_n (rst_n),
    .bus           (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU; illegal codes return a distinctive pattern so a missed hold is visible.
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res = 16'h5A5A;
    case (bus.output_ALUOp)
      3'b000: alu_res = bus.output_ALU_A + bus.output_ALU_B;
      3'b001: alu_res = bus.output_ALU_A - bus.output_ALU_B;
      3'b010: alu_res = bus.output_ALU_A & bus.output_ALU_B;
      3'b011: alu_res = bus.output_ALU_A | bus.output_ALU_B;
      3'b100: alu_res = bus.output_ALU_A ^ bus.output_ALU_B;
      default: alu_res = 16'h5A5A;
    endcase
  end
  assign bus.input_ALUResult = alu_res;
  assign bus.input_Zero      = (alu_res == '0) || (bus.output_ALUOp > 3'b100);
  assign bus.input_Negative  = alu_res[WIDTH-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [1:0] br,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] imm, input logic use_imm);
    @(negedge clk);
    bus.input_Op     = op;
    bus.input_Branch = br;
    bus.input_RegA   = a;
    bus.input_RegB   = b;
    bus.input_Imm    = imm;
    bus.input_UseImm = use_imm;
    bus.input_Start  = 1'b1;
    @(posedge clk);
    #1;
    bus.input_Start = 1'b0;
    bus.input_RegA  = 16'hDEAD;
    bus.input_RegB  = 16'hBEEF;
    bus.input_Imm   = 16'hCAFE;
    check("exec_busy", {31'd0, bus.output_Busy}, 32'd1);
    check("exec_done", {31'd0, bus.output_Done}, 32'd0);
    @(posedge clk);
    #1;
    check("done_pulse", {31'd0, bus.output_Done}, 32'd1);
    @(posedge clk);
    #1;
    check("idle_done", {31'd0, bus.output_Done}, 32'd0);
    check("idle_busy", {31'd0, bus.output_Busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    int n_idle;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.input_Start  = 1'b0;
    bus.input_Op     = 3'b000;
    bus.input_Branch = 2'b00;
    bus.input_RegA   = '0;
    bus.input_RegB   = '0;
    bus.input_Imm    = '0;
    bus.input_UseImm = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_aluout", {16'd0, bus.output_ALUOut}, 32'd0);
    check("rst_aluop",  {29'd0, bus.output_ALUOp}, 32'd0);
    check("rst_busy",   {31'd0, bus.output_Busy}, 32'd0);
    check("rst_illegal",{31'd0, bus.output_IllegalOp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b000, 2'b00, 16'h1234, 16'h0F0F, 16'h0000, 1'b0);
    check("add_out",  {16'd0, bus.output_ALUOut}, 32'h2143);
    check("add_zero", {31'd0, bus.output_Zero}, 32'd0);
    check("add_neg",  {31'd0, bus.output_Negative}, 32'd0);
    check("add_bt",   {31'd0, bus.output_BranchTaken}, 32'd0);
    check("add_opa",  {16'd0, bus.output_ALU_A}, 32'h1234);

    run_op(3'b001, 2'b00, 16'h0005, 16'h0007, 16'h0000, 1'b0);
    check("sub_out", {16'd0, bus.output_ALUOut}, 32'hFFFE);
    check("sub_neg", {31'd0, bus.output_Negative}, 32'd1);
    check("sub_bt",  {31'd0, bus.output_BranchTaken}, 32'd0);

    run_op(3'b000, 2'b11, 16'h0005, 16'h0007, 16'h0000, 1'b0);
    check("blt_op",  {29'd0, bus.output_ALUOp}, 32'd1);
    check("blt_out", {16'd0, bus.output_ALUOut}, 32'hFFFE);
    check("blt_bt",  {31'd0, bus.output_BranchTaken}, 32'd1);

    run_op(3'b010, 2'b01, 16'h00AA, 16'h00AA, 16'h0000, 1'b0);
    check("beq_op",   {29'd0, bus.output_ALUOp}, 32'd1);
    check("beq_out",  {16'd0, bus.output_ALUOut}, 32'h0000);
    check("beq_zero", {31'd0, bus.output_Zero}, 32'd1);
    check("beq_bt",   {31'd0, bus.output_BranchTaken}, 32'd1);

    run_op(3'b010, 2'b10, 16'h00AA, 16'h00AA, 16'h0000, 1'b0);
    check("bne_bt", {31'd0, bus.output_BranchTaken}, 32'd0);

    run_op(3'b111, 2'b01, 16'h0003, 16'h0003, 16'h0000, 1'b0);
    check("br_op7_illegal", {31'd0, bus.output_IllegalOp}, 32'd0);
    check("br_op7_bt",      {31'd0, bus.output_BranchTaken}, 32'd1);

    run_op(3'b010, 2'b00, 16'hF0F0, 16'h0000, 16'hFFFF, 1'b1);
    check("imm_b",   {16'd0, bus.output_ALU_B}, 32'hFFFF);
    check("imm_out", {16'd0, bus.output_ALUOut}, 32'hF0F0);
    check("imm_neg", {31'd0, bus.output_Negative}, 32'd1);

    run_op(3'b000, 2'b00, 16'h1234, 16'h0F0F, 16'h0000, 1'b0);
    run_op(3'b110, 2'b00, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    check("ill_flag", {31'd0, bus.output_IllegalOp}, 32'd1);
    check("ill_out",  {16'd0, bus.output_ALUOut}, 32'h2143);
    check("ill_zero", {31'd0, bus.output_Zero}, 32'd0);

    run_op(3'b101, 2'b00, 16'h0001, 16'h0001, 16'h0000, 1'b0);
    check("op5_illegal", {31'd0, bus.output_IllegalOp}, 32'd1);

    run_op(3'b100, 2'b00, 16'h00FF, 16'h0F0F, 16'h0000, 1'b0);
    check("xor_illegal", {31'd0, bus.output_IllegalOp}, 32'd0);
    check("xor_out",     {16'd0, bus.output_ALUOut}, 32'h0FF0);

    // Start held high: one operation every three cycles.
    @(negedge clk);
    bus.input_Op     = 3'b000;
    bus.input_Branch = 2'b00;
    bus.input_Start  = 1'b1;
    n_done = 0;
    n_idle = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.output_Done) n_done++;
      if (!bus.output_Busy) n_idle++;
    end
    bus.input_Start = 1'b0;
    check("cont_done", n_done, 32'd4);
    check("cont_idle", n_idle, 32'd4);

    // Reset during EXEC aborts the operation.
    @(negedge clk);
    bus.input_Op    = 3'b001;
    bus.input_RegA  = 16'h0009;
    bus.input_RegB  = 16'h0002;
    bus.input_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.input_Start = 1'b0;
    check("abort_busy_pre", {31'd0, bus.output_Busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_aluout", {16'd0, bus.output_ALUOut}, 32'd0);
    check("abort_alua",   {16'd0, bus.output_ALU_A}, 32'd0);
    check("abort_aluop",  {29'd0, bus.output_ALUOp}, 32'd0);
    check("abort_busy",   {31'd0, bus.output_Busy}, 32'd0);
    @(posedge clk);
    #1;
    check("abort_done", {31'd0, bus.output_Done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_idle_busy", {31'd0, bus.output_Busy}, 32'd0);
    check("abort_idle_done", {31'd0, bus.output_Done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
